// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: reads a 16-bit word count, payload words
// (little-endian) and an XOR checksum, writing each word and holding the core until done.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        start,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] widx_q, widx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        xfer;
  logic [15:0] n_full;

  assign xfer   = in_valid && ready_q;
  assign n_full = {in_data, cnt_q[7:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      LEN0: if (xfer) begin
        cnt_d[7:0] = in_data;
        state_d    = LEN1;
      end
      LEN1: if (xfer) begin
        cnt_d[15:8] = in_data;
        if ({16'd0, n_full} > 32'(MAX_WORDS)) state_d = ERR;
        else if (n_full == 16'd0)              state_d = CSUM;
        else                                   state_d = DATA;
      end
      DATA: if (xfer) begin
        csum_d = csum_q ^ in_data;
        bcnt_d = bcnt_q + 2'd1;
        case (bcnt_q)
          2'd0: word_d[7:0]   = in_data;
          2'd1: word_d[15:8]  = in_data;
          2'd2: word_d[23:16] = in_data;
          default: begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {14'd0, widx_q, 2'b00};
            wdata_d = {in_data, word_q};
            widx_d  = widx_q + 16'd1;
            if (widx_q == cnt_q - 16'd1) state_d = CSUM;
          end
        endcase
      end
      CSUM: if (xfer) state_d = (in_data == csum_q) ? DONE : ERR;
      default: if (start) begin
        state_d = LEN0;
        cnt_d   = '0;
        widx_d  = '0;
        bcnt_d  = '0;
        word_d  = '0;
        csum_d  = '0;
      end
    endcase
    // Status outputs are registered decodes of the next state.
    ready_d = (state_d != DONE) && (state_d != ERR);
    hold_d  = (state_d != DONE);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LEN0;
      cnt_q   <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_hold  = hold_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first loaded word.
REQ-002 SHALL have parameter MAX_WORDS, default 256, largest accepted word count.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  byte-stream source has a byte.
REQ-006 SHALL have port in_data  input  8  stream byte.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte; transfer when in_valid and in_ready are both high at a rising edge.
REQ-008 SHALL have port start  input  1  restart request, honoured only in DONE or ERR.
REQ-009 SHALL have port imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  output  32  write byte address.
REQ-011 SHALL have port imem_wdata  output  32  write word.
REQ-012 SHALL have port core_hold  output  1  high holds the processor PC at its reset value.
REQ-013 SHALL have port done  output  1  image loaded and checksum good.
REQ-014 SHALL have port error  output  1  load failed.

Function
REQ-015 SHALL implement states LEN0, LEN1, DATA, CSUM, DONE, ERR.
REQ-016 Stream format SHALL be: count low byte, count high byte (16-bit N), then 4*N payload bytes, each word little-endian, then one checksum byte.
REQ-017 in_ready SHALL be high in LEN0, LEN1, DATA and CSUM, and low in DONE and ERR.
REQ-018 LEN0 SHALL capture the low byte on transfer and go to LEN1.
REQ-019 LEN1 SHALL capture the high byte on transfer, then go to ERR if N > MAX_WORDS, to CSUM if N == 0, else to DATA.
REQ-020 DATA SHALL assemble bytes into bits [7:0], [15:8], [23:16] and [31:24] in arrival order, using a 2-bit byte counter.
REQ-021 On the 4th byte of word k (0-based), imem_we SHALL be high for exactly the next cycle, with imem_addr = BASE_ADDR + 4*k and imem_wdata = the assembled word (registered, latency 1 cycle).
REQ-022 After the write of word N-1 is issued, the state SHALL go to CSUM; word index wraps only by restart.
REQ-023 The running checksum SHALL be the XOR of all payload bytes, excluding the count and checksum bytes, cleared on entry to LEN0.
REQ-024 CSUM SHALL, on transfer, go to DONE if the byte equals the running XOR, else to ERR.
REQ-025 No transfer cycle (in_valid low) SHALL change any state, counter or checksum; gaps of any length are legal.
REQ-026 core_hold SHALL be high in every state except DONE.
REQ-027 done SHALL be high only in DONE; error SHALL be high only in ERR.
REQ-028 start high in DONE or ERR SHALL go to LEN0 next cycle and clear word index, byte counter and checksum; start in other states SHALL be ignored.
REQ-029 imem_we SHALL never be high outside the cycle after a DATA word completion.

Reset
REQ-030 rst high SHALL immediately force state LEN0, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, done=0, error=0, and clear all counters and the checksum.
REQ-031 rst asserted mid-load SHALL abort the load with no further imem_we; the next load SHALL restart from the count bytes.
REQ-032 Release of rst SHALL take effect at the next rising clk edge.

Verification
REQ-033 Stream 02 00 | 13 00 00 00 | 93 00 10 00 | 90 -> writes 0x00000013 @0x0 and 0x00100093 @0x4, one cycle each, then done=1, core_hold=0.
REQ-034 Same stream with checksum 91 -> no further effect after the two writes; error=1, core_hold=1, in_ready=0.
REQ-035 Stream 00 00 00 -> no imem_we, done=1; stream 00 00 01 -> error=1.
REQ-036 Count 01 01 (N=257) with MAX_WORDS=256 -> error=1 right after the second byte, no writes.
REQ-037 Vector of REQ-033 with in_valid low for 3 cycles between every byte -> identical write sequence and done=1.
REQ-038 rst pulsed after 6 payload bytes, then the full REQ-033 stream followed by start in DONE -> clean load, start returns to LEN0 with core_hold=1.
